// File: rtl/parser_layer_rule_match_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | parser_layer_rule_match_if                                                 |
// | Header stream, match result and config bus of the per-layer rule matcher.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface parser_layer_rule_match_if #(
  parameter int HEAD_WIDTH       = 512,
  parameter int TYPE_WIDTH       = 8,
  parameter int TYPE_NUM         = 2,
  parameter int RULE_NUM         = 8,
  parameter int KEY_FILED_NUM    = 8,
  parameter int KEY_OFFSET_WIDTH = 5,
  parameter int HEAD_SHIFT_WIDTH = 5,
  parameter int META_SHIFT_WIDTH = 5,
  parameter int CNT_WIDTH        = 32
);
  localparam int TOW     = $clog2(HEAD_WIDTH / TYPE_WIDTH);
  localparam int RIW     = $clog2(RULE_NUM);
  localparam int KOW     = KEY_FILED_NUM * (KEY_OFFSET_WIDTH + 1);
  localparam int RULE_W  = 1 + 2 * TYPE_NUM * TYPE_WIDTH + KOW + HEAD_SHIFT_WIDTH + META_SHIFT_WIDTH;
  localparam int OFFW    = TYPE_NUM * TOW;
  localparam int CFG_DW0 = (RULE_W > CNT_WIDTH) ? RULE_W : CNT_WIDTH;
  localparam int CFG_DW  = (CFG_DW0 > OFFW) ? CFG_DW0 : OFFW;

  logic                        i_head_valid;
  logic [HEAD_WIDTH-1:0]       i_head;
  logic                        o_head_ready;
  logic                        o_valid;
  logic                        i_ready;
  logic [HEAD_WIDTH-1:0]       o_head;
  logic                        o_hit;
  logic [RIW-1:0]              o_rule_idx;
  logic [KOW-1:0]              o_key_offset;
  logic [HEAD_SHIFT_WIDTH-1:0] o_head_shift;
  logic [META_SHIFT_WIDTH-1:0] o_meta_shift;
  logic                        i_cfg_wren;
  logic                        i_cfg_rden;
  logic [RIW+1:0]              i_cfg_addr;
  logic [CFG_DW-1:0]           i_cfg_wdata;
  logic [CFG_DW-1:0]           o_cfg_rdata;
  logic                        o_cfg_rvalid;

  modport master (
    output i_head_valid, i_head, i_ready, i_cfg_wren, i_cfg_rden, i_cfg_addr, i_cfg_wdata,
    input  o_head_ready, o_valid, o_head, o_hit, o_rule_idx, o_key_offset,
           o_head_shift, o_meta_shift, o_cfg_rdata, o_cfg_rvalid
  );

  modport slave (
    input  i_head_valid, i_head, i_ready, i_cfg_wren, i_cfg_rden, i_cfg_addr, i_cfg_wdata,
    output o_head_ready, o_valid, o_head, o_hit, o_rule_idx, o_key_offset,
           o_head_shift, o_meta_shift, o_cfg_rdata, o_cfg_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/parser_layer_rule_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | parser_layer_rule_match                                                    |
// | Two-stage type extract + masked priority rule match with config/counters. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module parser_layer_rule_match #(
  parameter int HEAD_WIDTH       = 512,
  parameter int TYPE_WIDTH       = 8,
  parameter int TYPE_NUM         = 2,
  parameter int RULE_NUM         = 8,
  parameter int KEY_FILED_NUM    = 8,
  parameter int KEY_OFFSET_WIDTH = 5,
  parameter int HEAD_SHIFT_WIDTH = 5,
  parameter int META_SHIFT_WIDTH = 5,
  parameter int CNT_WIDTH        = 32
) (
  input logic i_clk,
  input logic i_rst,
  parser_layer_rule_match_if.slave bus
);
  localparam int TOW       = $clog2(HEAD_WIDTH / TYPE_WIDTH);
  localparam int RIW       = $clog2(RULE_NUM);
  localparam int KOW       = KEY_FILED_NUM * (KEY_OFFSET_WIDTH + 1);
  localparam int TFW       = TYPE_NUM * TYPE_WIDTH;
  localparam int RULE_W    = 1 + 2 * TFW + KOW + HEAD_SHIFT_WIDTH + META_SHIFT_WIDTH;
  localparam int OFFW      = TYPE_NUM * TOW;
  localparam int CFG_DW0   = (RULE_W > CNT_WIDTH) ? RULE_W : CNT_WIDTH;
  localparam int CFG_DW    = (CFG_DW0 > OFFW) ? CFG_DW0 : OFFW;
  localparam int HS_LSB    = META_SHIFT_WIDTH;
  localparam int KEY_LSB   = HS_LSB + HEAD_SHIFT_WIDTH;
  localparam int MASK_LSB  = KEY_LSB + KOW;
  localparam int DATA_LSB  = MASK_LSB + TFW;
  localparam int VALID_BIT = DATA_LSB + TFW;
  localparam int POS_NUM   = HEAD_WIDTH / TYPE_WIDTH;

  logic                        w_en;
  logic                        r_s1_valid;
  logic [HEAD_WIDTH-1:0]       r_s1_head;
  logic [TYPE_WIDTH-1:0]       r_s1_type [TYPE_NUM];
  logic [TYPE_WIDTH-1:0]       w_type [TYPE_NUM];
  logic [RULE_W-1:0]           r_rule [RULE_NUM];
  logic [OFFW-1:0]             r_type_off;
  logic [CNT_WIDTH-1:0]        r_hit_cnt [RULE_NUM];
  logic [CNT_WIDTH-1:0]        r_miss_cnt;
  logic [RULE_NUM-1:0]         w_match;
  logic [RIW-1:0]              w_win;
  logic [RULE_W-1:0]           w_win_rule;
  logic                        w_hit;
  logic                        w_load;
  logic [1:0]                  w_region;
  logic [RIW-1:0]              w_idx;
  logic [CFG_DW-1:0]           w_rdata;

  logic                        r_valid;
  logic [HEAD_WIDTH-1:0]       r_head;
  logic                        r_hit;
  logic [RIW-1:0]              r_idx;
  logic [KOW-1:0]              r_key;
  logic [HEAD_SHIFT_WIDTH-1:0] r_hs;
  logic [META_SHIFT_WIDTH-1:0] r_ms;
  logic                        r_rvalid;
  logic [CFG_DW-1:0]           r_rdata;

  // Every stage advances together; a stalled output freezes the whole pipe.
  assign w_en     = !r_valid || bus.i_ready;
  assign w_region = bus.i_cfg_addr[RIW+1:RIW];
  assign w_idx    = bus.i_cfg_addr[RIW-1:0];

  generate
    for (genvar k = 0; k < TYPE_NUM; k++) begin : g_type
      logic [TOW-1:0] w_off;
      assign w_off = r_type_off[(TYPE_NUM-k)*TOW-1 -: TOW];
      always_comb begin
        w_type[k] = '0;
        for (int j = 0; j < POS_NUM; j++) begin
          if (w_off == TOW'(j)) begin
            w_type[k] = bus.i_head[HEAD_WIDTH-1-TYPE_WIDTH*j -: TYPE_WIDTH];
          end
        end
      end
    end

    for (genvar r = 0; r < RULE_NUM; r++) begin : g_rule
      logic [TYPE_NUM-1:0] w_fmatch;
      for (genvar k = 0; k < TYPE_NUM; k++) begin : g_field
        assign w_fmatch[k] =
          ((r_s1_type[k] ^ r_rule[r][DATA_LSB+(TYPE_NUM-1-k)*TYPE_WIDTH +: TYPE_WIDTH]) &
            r_rule[r][MASK_LSB+(TYPE_NUM-1-k)*TYPE_WIDTH +: TYPE_WIDTH]) == '0;
      end
      assign w_match[r] = r_rule[r][VALID_BIT] && (&w_fmatch);
    end
  endgenerate

  always_comb begin
    w_win = '0;
    for (int r = RULE_NUM - 1; r >= 0; r--) begin
      if (w_match[r]) begin
        w_win = RIW'(r);
      end
    end
  end

  assign w_win_rule = r_rule[w_win];
  assign w_hit      = r_s1_valid && (|w_match);
  assign w_load     = w_en && r_s1_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_head  <= '0;
      for (int k = 0; k < TYPE_NUM; k++) r_s1_type[k] <= '0;
      r_valid    <= 1'b0;
      r_head     <= '0;
      r_hit      <= 1'b0;
      r_idx      <= '0;
      r_key      <= '0;
      r_hs       <= '0;
      r_ms       <= '0;
    end else if (w_en) begin
      r_s1_valid <= bus.i_head_valid;
      r_s1_head  <= bus.i_head;
      for (int k = 0; k < TYPE_NUM; k++) r_s1_type[k] <= w_type[k];
      r_valid    <= r_s1_valid;
      r_head     <= r_s1_head;
      r_hit      <= w_hit;
      if (w_hit) begin
        r_idx <= w_win;
        r_key <= w_win_rule[KEY_LSB +: KOW];
        r_hs  <= w_win_rule[HS_LSB +: HEAD_SHIFT_WIDTH];
        r_ms  <= w_win_rule[META_SHIFT_WIDTH-1:0];
      end else begin
        r_idx <= '0;
        r_key <= '0;
        r_hs  <= '0;
        r_ms  <= '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < RULE_NUM; r++) r_rule[r] <= '0;
      r_type_off <= '0;
    end else if (bus.i_cfg_wren) begin
      if (w_region == 2'd0) r_rule[w_idx] <= bus.i_cfg_wdata[RULE_W-1:0];
      if (w_region == 2'd3) r_type_off <= bus.i_cfg_wdata[OFFW-1:0];
    end
  end

  // A clear in the same cycle as an increment leaves the counter at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < RULE_NUM; r++) r_hit_cnt[r] <= '0;
      r_miss_cnt <= '0;
    end else begin
      for (int r = 0; r < RULE_NUM; r++) begin
        if (bus.i_cfg_wren && w_region == 2'd1 && w_idx == RIW'(r)) begin
          r_hit_cnt[r] <= '0;
        end else if (w_load && w_hit && w_win == RIW'(r) && r_hit_cnt[r] != '1) begin
          r_hit_cnt[r] <= r_hit_cnt[r] + CNT_WIDTH'(1);
        end
      end
      if (bus.i_cfg_wren && w_region == 2'd2) begin
        r_miss_cnt <= '0;
      end else if (w_load && !w_hit && r_miss_cnt != '1) begin
        r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_region)
      2'd0:    w_rdata[RULE_W-1:0]    = r_rule[w_idx];
      2'd1:    w_rdata[CNT_WIDTH-1:0] = r_hit_cnt[w_idx];
      2'd2:    w_rdata[CNT_WIDTH-1:0] = r_miss_cnt;
      default: w_rdata[OFFW-1:0]      = r_type_off;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= bus.i_cfg_rden;
      if (bus.i_cfg_rden) r_rdata <= w_rdata;
    end
  end

  assign bus.o_head_ready = w_en;
  assign bus.o_valid      = r_valid;
  assign bus.o_head       = r_head;
  assign bus.o_hit        = r_hit;
  assign bus.o_rule_idx   = r_idx;
  assign bus.o_key_offset = r_key;
  assign bus.o_head_shift = r_hs;
  assign bus.o_meta_shift = r_ms;
  assign bus.o_cfg_rvalid = r_rvalid;
  assign bus.o_cfg_rdata  = r_rdata;
endmodule
`default_nettype wire

// File: tb/tb_parser_layer_rule_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_parser_layer_rule_match                                                 |
// | Scoreboard bench for the rule matcher (32-bit and 4-bit counter builds).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_parser_layer_rule_match;
  localparam int HW     = 512;
  localparam int TN     = 2;
  localparam int RN     = 8;
  localparam int TOW    = 6;
  localparam int KW     = 48;
  localparam int RULE_W = 91;
  localparam int CFG_DW = 91;

  typedef struct packed {
    logic           v;
    logic [7:0]     d0, d1, m0, m1;
    logic [KW-1:0]  key;
    logic [4:0]     hs, ms;
  } rule_t;

  typedef struct packed {
    logic [HW-1:0] head;
    logic          hit;
    logic [2:0]    idx;
    logic [KW-1:0] key;
    logic [4:0]    hs, ms;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  parser_layer_rule_match_if #(.CNT_WIDTH(32)) bus ();
  parser_layer_rule_match_if #(.CNT_WIDTH(4))  bus4 ();

  parser_layer_rule_match #(.CNT_WIDTH(32)) dut  (.i_clk(clk), .i_rst(rst), .bus(bus));
  parser_layer_rule_match #(.CNT_WIDTH(4))  dut4 (.i_clk(clk), .i_rst(rst), .bus(bus4));

  assign bus4.i_head_valid = bus.i_head_valid;
  assign bus4.i_head       = bus.i_head;
  assign bus4.i_ready      = bus.i_ready;
  assign bus4.i_cfg_wren   = bus.i_cfg_wren;
  assign bus4.i_cfg_rden   = bus.i_cfg_rden;
  assign bus4.i_cfg_addr   = bus.i_cfg_addr;
  assign bus4.i_cfg_wdata  = bus.i_cfg_wdata;

  int    checks   = 0;
  int    failures = 0;
  res_t  exp_q[$];
  rule_t m_rule [RN];
  logic [TOW-1:0] m_off [TN];
  res_t  mon_got, mon_exp;

  function automatic logic [CFG_DW-1:0] mk_rule(input logic v, input logic [7:0] d0, d1, m0, m1,
                                                 input logic [KW-1:0] key, input logic [4:0] hs, ms);
    return {v, d0, d1, m0, m1, key, hs, ms};
  endfunction

  function automatic logic [HW-1:0] set_byte(input logic [HW-1:0] h, input int idx, input logic [7:0] v);
    logic [HW-1:0] m, s;
    m = {8'hFF, {(HW-8){1'b0}}} >> (8 * idx);
    s = {v, {(HW-8){1'b0}}} >> (8 * idx);
    return (h & ~m) | s;
  endfunction

  function automatic logic [HW-1:0] mk_head(input logic [7:0] b0, b1);
    logic [HW-1:0] h;
    for (int i = 0; i < HW / 32; i++) h[i*32 +: 32] = $urandom;
    h = set_byte(h, 0, b0);
    return set_byte(h, 1, b1);
  endfunction

  function automatic res_t model(input logic [HW-1:0] h);
    res_t e;
    logic [7:0] t [TN];
    logic [HW-1:0] s;
    rule_t rr;
    e = '0;
    e.head = h;
    for (int k = 0; k < TN; k++) begin
      s = h << (8 * int'(m_off[k]));
      t[k] = s[HW-1 -: 8];
    end
    for (int r = RN - 1; r >= 0; r--) begin
      rr = m_rule[r];
      if (rr.v && (((t[0] ^ rr.d0) & rr.m0) == 8'h00) && (((t[1] ^ rr.d1) & rr.m1) == 8'h00)) begin
        e.hit = 1'b1;
        e.idx = 3'(r);
        e.key = rr.key;
        e.hs  = rr.hs;
        e.ms  = rr.ms;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.o_valid && bus.i_ready) begin
      mon_got = {bus.o_head, bus.o_hit, bus.o_rule_idx, bus.o_key_offset, bus.o_head_shift, bus.o_meta_shift};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL result_unexpected: got hit=%0b idx=%0d with nothing expected", mon_got.hit, mon_got.idx);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL result: got hit=%0b idx=%0d key=%h hs=%0d ms=%0d head=%h, expected hit=%0b idx=%0d key=%h hs=%0d ms=%0d head=%h",
                   mon_got.hit, mon_got.idx, mon_got.key, mon_got.hs, mon_got.ms, mon_got.head[HW-1 -: 64],
                   mon_exp.hit, mon_exp.idx, mon_exp.key, mon_exp.hs, mon_exp.ms, mon_exp.head[HW-1 -: 64]);
        end
      end
    end
  end

  task automatic send_header(input logic [HW-1:0] h);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    bus.i_head_valid = 1'b1;
    bus.i_head = h;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.o_head_ready;
      @(posedge clk);
      n++;
    end
    if (acc) begin
      exp_q.push_back(model(h));
    end else begin
      checks++;
      failures++;
      $display("FAIL send_timeout: header not accepted in %0d cycles", n);
    end
    #1 bus.i_head_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [4:0] addr, input logic [CFG_DW-1:0] d);
    bus.i_cfg_wren = 1'b1;
    bus.i_cfg_addr = addr;
    bus.i_cfg_wdata = d;
    @(posedge clk);
    #1 bus.i_cfg_wren = 1'b0;
    if (addr[4:3] == 2'd0) m_rule[addr[2:0]] = d[RULE_W-1:0];
    if (addr[4:3] == 2'd3) begin
      m_off[0] = d[2*TOW-1:TOW];
      m_off[1] = d[TOW-1:0];
    end
  endtask

  task automatic cfg_read(input logic [4:0] addr, output logic [CFG_DW-1:0] d, output logic [CFG_DW-1:0] d4);
    bus.i_cfg_rden = 1'b1;
    bus.i_cfg_addr = addr;
    @(posedge clk);
    #1 bus.i_cfg_rden = 1'b0;
    checks++;
    if (bus.o_cfg_rvalid !== 1'b1) begin
      failures++;
      $display("FAIL cfg_rvalid: got %b required 1 (addr %h)", bus.o_cfg_rvalid, addr);
    end
    d = bus.o_cfg_rdata;
    d4 = bus4.o_cfg_rdata;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_hit !== 1'b0 || bus.o_rule_idx !== 3'd0) begin
      failures++;
      $display("FAIL reset_result: valid=%b hit=%b idx=%0d required 0/0/0", bus.o_valid, bus.o_hit, bus.o_rule_idx);
    end
    checks++;
    if (bus.o_key_offset !== '0 || bus.o_head_shift !== '0 || bus.o_meta_shift !== '0 || bus.o_head !== '0) begin
      failures++;
      $display("FAIL reset_fields: key=%h hs=%0d ms=%0d required 0", bus.o_key_offset, bus.o_head_shift, bus.o_meta_shift);
    end
    checks++;
    if (bus.o_cfg_rvalid !== 1'b0 || bus.o_cfg_rdata !== '0) begin
      failures++;
      $display("FAIL reset_cfg: rvalid=%b rdata=%h required 0", bus.o_cfg_rvalid, bus.o_cfg_rdata);
    end
    checks++;
    if (bus.o_head_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b required 1", bus.o_head_ready);
    end
  endtask

  task automatic test_miss_latency();
    logic [CFG_DW-1:0] d, d4;
    send_header(mk_head(8'h08, 8'h00));
    checks++;
    if (bus.o_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early: o_valid=%b one cycle after accept, required 0", bus.o_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_hit !== 1'b0) begin
      failures++;
      $display("FAIL latency: o_valid=%b o_hit=%b two cycles after accept, required 1/0", bus.o_valid, bus.o_hit);
    end
    wait_drain();
    cfg_read(5'b10000, d, d4);
    checks++;
    if (d !== 91'd1 || d4 !== 91'd1) begin
      failures++;
      $display("FAIL miss_cnt: got %0d/%0d required 1", d, d4);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_cfg_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rvalid_pulse: got %b required 0", bus.o_cfg_rvalid);
    end
  endtask

  task automatic test_rule_hit();
    logic [CFG_DW-1:0] d, d4, r3, r7;
    logic [HW-1:0] h;
    cfg_write(5'b11000, {{(CFG_DW-12){1'b0}}, 6'd0, 6'd1});
    cfg_read(5'b11000, d, d4);
    checks++;
    if (d !== 91'd1) begin
      failures++;
      $display("FAIL type_off_read: got %h required 1", d);
    end
    r3 = mk_rule(1'b1, 8'h08, 8'h00, 8'hFF, 8'hFF, 48'h8A5_1C3_F02_E47, 5'd7, 5'd3);
    cfg_write(5'd3, r3);
    cfg_read(5'd3, d, d4);
    checks++;
    if (d !== r3) begin
      failures++;
      $display("FAIL rule_read: got %h required %h", d, r3);
    end
    send_header(mk_head(8'h08, 8'h00));
    send_header(mk_head(8'h08, 8'h01));
    // Second layout: type fields at byte offsets 5 and 9.
    cfg_write(5'd4, mk_rule(1'b1, 8'h5A, 8'hC3, 8'hFF, 8'hFF, 48'hFED_CBA_987_654, 5'd31, 5'd12));
    cfg_write(5'b11000, {{(CFG_DW-12){1'b0}}, 6'd5, 6'd9});
    h = set_byte(set_byte(mk_head(8'h08, 8'h00), 5, 8'h5A), 9, 8'hC3);
    send_header(h);
    cfg_write(5'b11000, {{(CFG_DW-12){1'b0}}, 6'd0, 6'd1});
    wait_drain();
    cfg_read(5'b01011, d, d4);
    checks++;
    if (d !== 91'd1) begin
      failures++;
      $display("FAIL hit_cnt3: got %0d required 1", d);
    end
    cfg_read(5'b01100, d, d4);
    checks++;
    if (d !== 91'd1) begin
      failures++;
      $display("FAIL hit_cnt4: got %0d required 1", d);
    end
    cfg_read(5'b10000, d, d4);
    checks++;
    if (d !== 91'd2) begin
      failures++;
      $display("FAIL miss_cnt2: got %0d required 2", d);
    end
    // Read and write of rule 7 in the same cycle returns the previous contents.
    r7 = mk_rule(1'b1, 8'hEE, 8'hEE, 8'hFF, 8'hFF, 48'h111_222_333_444, 5'd1, 5'd1);
    bus.i_cfg_wren = 1'b1;
    bus.i_cfg_rden = 1'b1;
    bus.i_cfg_addr = 5'd7;
    bus.i_cfg_wdata = r7;
    @(posedge clk);
    #1;
    bus.i_cfg_wren = 1'b0;
    bus.i_cfg_rden = 1'b0;
    m_rule[7] = r7[RULE_W-1:0];
    checks++;
    if (bus.o_cfg_rdata !== '0) begin
      failures++;
      $display("FAIL rw_same: got %h required 0", bus.o_cfg_rdata);
    end
    cfg_read(5'd7, d, d4);
    checks++;
    if (d !== r7) begin
      failures++;
      $display("FAIL rw_after: got %h required %h", d, r7);
    end
  endtask

  task automatic test_priority();
    cfg_write(5'd2, mk_rule(1'b1, 8'h08, 8'h00, 8'h00, 8'h00, 48'hAAA_AAA_AAA_AAA, 5'd2, 5'd1));
    cfg_write(5'd5, mk_rule(1'b1, 8'h11, 8'h22, 8'hFF, 8'hFF, 48'h055_055_055_055, 5'd9, 5'd17));
    send_header(mk_head(8'h11, 8'h22));
    send_header(mk_head(8'h08, 8'h00));
    cfg_write(5'd2, mk_rule(1'b0, 8'h08, 8'h00, 8'h00, 8'h00, 48'hAAA_AAA_AAA_AAA, 5'd2, 5'd1));
    send_header(mk_head(8'h11, 8'h22));
    send_header(mk_head(8'h08, 8'h00));
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [7:0] b0 [6] = '{8'h08, 8'h11, 8'h33, 8'h11, 8'h08, 8'hEE};
    logic [7:0] b1 [6] = '{8'h00, 8'h22, 8'h44, 8'h22, 8'h00, 8'hEE};
    logic [HW-1:0] snap;
    fork
      begin
        for (int i = 0; i < 6; i++) send_header(mk_head(b0[i], b1[i]));
      end
      begin
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        snap = bus.o_head;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          checks++;
          if (bus.o_head_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_ready: cycle %0d got %b required 0", c, bus.o_head_ready);
          end
          checks++;
          if (bus.o_valid !== 1'b1 || bus.o_head !== snap) begin
            failures++;
            $display("FAIL stall_hold: cycle %0d valid=%b head_changed=%b required 1/0", c, bus.o_valid, bus.o_head !== snap);
          end
          @(posedge clk);
          #1;
        end
        bus.i_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_write_collision();
    logic [HW-1:0] h;
    h = mk_head(8'hAB, 8'hCD);
    send_header(h);
    cfg_write(5'd6, mk_rule(1'b1, 8'hAB, 8'hCD, 8'hFF, 8'hFF, 48'h3C3_C3C_3C3_C3C, 5'd20, 5'd30));
    send_header(h);
    wait_drain();
  endtask

  task automatic test_counter_sat();
    logic [CFG_DW-1:0] d, d4;
    cfg_write(5'd0, mk_rule(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 48'h000_FFF_000_FFF, 5'd1, 5'd2));
    for (int i = 0; i < 20; i++) send_header(mk_head(8'($urandom), 8'($urandom)));
    wait_drain();
    cfg_read(5'b01000, d, d4);
    checks++;
    if (d !== 91'd20 || d4 !== 91'd15) begin
      failures++;
      $display("FAIL hit_sat: got %0d/%0d required 20/15", d, d4);
    end
    send_header(mk_head(8'h99, 8'h77));
    cfg_write(5'b01000, '0);
    wait_drain();
    cfg_read(5'b01000, d, d4);
    checks++;
    if (d !== '0 || d4 !== '0) begin
      failures++;
      $display("FAIL clear_wins: got %0d/%0d required 0/0", d, d4);
    end
    send_header(mk_head(8'h42, 8'h24));
    wait_drain();
    cfg_read(5'b01000, d, d4);
    checks++;
    if (d !== 91'd1 || d4 !== 91'd1) begin
      failures++;
      $display("FAIL hit_after_clear: got %0d/%0d required 1/1", d, d4);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < RN; r++) m_rule[r] = '0;
    for (int k = 0; k < TN; k++) m_off[k] = '0;
    bus.i_head_valid = 1'b0;
    bus.i_head = '0;
    bus.i_ready = 1'b1;
    bus.i_cfg_wren = 1'b0;
    bus.i_cfg_rden = 1'b0;
    bus.i_cfg_addr = '0;
    bus.i_cfg_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_miss_latency();
    test_rule_hit();
    test_priority();
    test_back_to_back();
    test_write_collision();
    test_counter_sat();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_queue: %0d results never produced, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
